// File: rtl/fc_layer_scheduler.sv
// fc_layer_scheduler: runs FC1->FC2->FC3 one after another on a single shared fully_connected engine.
//   For each layer it sets up the engine (config outputs), pulses o_eng_start, then waits for i_eng_done.
//   Inputs:  clk, rst (async, active high), i_valid (start a run), i_eng_done (engine finished a layer).
//   Outputs: o_valid (run finished), o_busy, o_error (sticky watchdog timeout), o_layer (0..2),
//            o_eng_start, o_eng_n_in, o_eng_n_out, o_eng_wbase, o_eng_bbase,
//            o_eng_src, o_eng_dst, o_eng_relu (engine config), o_run_cycles (length of the last run).
module fc_layer_scheduler #(
  parameter int N_IN_FC1   = 576,
  parameter int N_OUT_FC1  = 64,
  parameter int N_OUT_FC2  = 64,
  parameter int N_OUT_FC3  = 2,
  parameter int CNT_WIDTH  = 10,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_error,
  output logic [1:0]            o_layer,
  output logic                  o_eng_start,
  output logic [CNT_WIDTH-1:0]  o_eng_n_in,
  output logic [CNT_WIDTH-1:0]  o_eng_n_out,
  output logic [ADDR_WIDTH-1:0] o_eng_wbase,
  output logic [ADDR_WIDTH-1:0] o_eng_bbase,
  output logic [1:0]            o_eng_src,
  output logic [1:0]            o_eng_dst,
  output logic                  o_eng_relu,
  input  logic                  i_eng_done,
  output logic [31:0]           o_run_cycles
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE, ERR} state_t;
  localparam logic [ADDR_WIDTH-1:0] WB1 = ADDR_WIDTH'(N_IN_FC1 * N_OUT_FC1);
  localparam logic [ADDR_WIDTH-1:0] WB2 = ADDR_WIDTH'(N_IN_FC1 * N_OUT_FC1 + N_OUT_FC1 * N_OUT_FC2);
  localparam logic [ADDR_WIDTH-1:0] BB1 = ADDR_WIDTH'(N_OUT_FC1);
  localparam logic [ADDR_WIDTH-1:0] BB2 = ADDR_WIDTH'(N_OUT_FC1 + N_OUT_FC2);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);
  state_t state, state_n;
  logic [31:0] wd;
  logic expired;
  assign expired = TIMEOUT != 0 && wd == WD_LAST;
  assign o_busy = state != IDLE;
  assign o_eng_start = state == START;
  assign o_valid = state == DONE;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = i_valid ? LOAD : IDLE;
      LOAD:    state_n = START;
      START:   state_n = WAIT;
      // a done arriving on the expiry cycle takes priority over the timeout
      WAIT:    state_n = i_eng_done ? (o_layer == 2'd2 ? DONE : LOAD) : (expired ? ERR : WAIT);
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wd           <= '0;
      o_error      <= 1'b0;
      o_layer      <= '0;
      o_eng_n_in   <= '0;
      o_eng_n_out  <= '0;
      o_eng_wbase  <= '0;
      o_eng_bbase  <= '0;
      o_eng_src    <= '0;
      o_eng_dst    <= '0;
      o_eng_relu   <= 1'b0;
      o_run_cycles <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: if (i_valid) begin
          o_layer      <= '0;
          o_error      <= 1'b0;
          o_run_cycles <= '0;
        end
        LOAD: begin
          o_eng_n_in  <= o_layer == 2'd0 ? CNT_WIDTH'(N_IN_FC1)  : o_layer == 2'd1 ? CNT_WIDTH'(N_OUT_FC1) : CNT_WIDTH'(N_OUT_FC2);
          o_eng_n_out <= o_layer == 2'd0 ? CNT_WIDTH'(N_OUT_FC1) : o_layer == 2'd1 ? CNT_WIDTH'(N_OUT_FC2) : CNT_WIDTH'(N_OUT_FC3);
          o_eng_wbase <= o_layer == 2'd0 ? '0 : o_layer == 2'd1 ? WB1 : WB2;
          o_eng_bbase <= o_layer == 2'd0 ? '0 : o_layer == 2'd1 ? BB1 : BB2;
          o_eng_src   <= o_layer;
          o_eng_dst   <= o_layer;
          o_eng_relu  <= o_layer != 2'd2;
        end
        START: wd <= '0;
        WAIT: begin
          if (i_eng_done && o_layer != 2'd2) o_layer <= o_layer + 2'd1;
          if (!i_eng_done) wd <= wd + 32'd1;
        end
        ERR: o_error <= 1'b1;
        default: ;
      endcase
      // run length covers LOAD through DONE and saturates instead of wrapping
      if ((state == LOAD || state == START || state == WAIT || state == DONE) && o_run_cycles != '1)
        o_run_cycles <= o_run_cycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_fc_layer_scheduler.sv
// tb_fc_layer_scheduler: directed checks of layer sequencing, config table, watchdog, reset and ignored inputs.
module tb_fc_layer_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_eng_done = 1'b0;
  logic        o_valid, o_busy, o_error, o_eng_start, o_eng_relu;
  logic [1:0]  o_layer, o_eng_src, o_eng_dst;
  logic [9:0]  o_eng_n_in, o_eng_n_out;
  logic [15:0] o_eng_wbase, o_eng_bbase;
  logic [31:0] o_run_cycles;
  int n_tests = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_valid = 0;
  int s0, v0;
  int e_n_in[3]  = '{576, 64, 64};
  int e_n_out[3] = '{64, 64, 2};
  int e_wb[3]    = '{0, 36864, 40960};
  int e_bb[3]    = '{0, 64, 128};
  int e_relu[3]  = '{1, 1, 0};

  fc_layer_scheduler #(.TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_valid(o_valid), .o_busy(o_busy),
    .o_error(o_error), .o_layer(o_layer), .o_eng_start(o_eng_start),
    .o_eng_n_in(o_eng_n_in), .o_eng_n_out(o_eng_n_out), .o_eng_wbase(o_eng_wbase),
    .o_eng_bbase(o_eng_bbase), .o_eng_src(o_eng_src), .o_eng_dst(o_eng_dst),
    .o_eng_relu(o_eng_relu), .i_eng_done(i_eng_done), .o_run_cycles(o_run_cycles)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_eng_start) n_start++;
    if (o_valid) n_valid++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 10 && !o_eng_start; i++) tick();
    chk("start_seen", o_eng_start, 1);
  endtask

  task automatic do_layer(input int l, input int dly);
    wait_start();
    chk("layer", o_layer, l);
    chk("n_in", o_eng_n_in, e_n_in[l]);
    chk("n_out", o_eng_n_out, e_n_out[l]);
    chk("wbase", o_eng_wbase, e_wb[l]);
    chk("bbase", o_eng_bbase, e_bb[l]);
    chk("src", o_eng_src, l);
    chk("dst", o_eng_dst, l);
    chk("relu", o_eng_relu, e_relu[l]);
    repeat (dly) tick();
    i_eng_done = 1'b1;
    tick();
    i_eng_done = 1'b0;
  endtask

  task automatic finish_run(input int cyc);
    chk("valid_pulse", o_valid, 1);
    tick();
    chk("valid_low", o_valid, 0);
    chk("idle", o_busy, 0);
    chk("run_cycles", o_run_cycles, cyc);
  endtask

  initial begin
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_start", o_eng_start, 0);
    chk("rst_n_in", o_eng_n_in, 0);
    chk("rst_cycles", o_run_cycles, 0);
    tick();
    rst = 1'b0;
    tick();
    // normal run, engine answers 5 WAIT cycles after start: 3*(LOAD+START+5)+DONE = 22
    s0 = n_start; v0 = n_valid;
    accept();
    chk("load_busy", o_busy, 1);
    chk("load_nostart", o_eng_start, 0);
    tick();
    chk("start_at_2", o_eng_start, 1);
    do_layer(0, 5);
    tick();
    chk("done_to_start_2", o_eng_start, 1);
    do_layer(1, 5);
    do_layer(2, 5);
    finish_run(22);
    chk("t1_starts", n_start - s0, 3);
    chk("t1_valids", n_valid - v0, 1);
    // second i_valid 3 cycles into the run is ignored
    s0 = n_start; v0 = n_valid;
    accept();
    fork
      begin
        repeat (2) tick();
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
      end
    join_none
    do_layer(0, 5);
    do_layer(1, 5);
    do_layer(2, 5);
    finish_run(22);
    repeat (3) tick();
    chk("t2_starts", n_start - s0, 3);
    chk("t2_valids", n_valid - v0, 1);
    // watchdog: layer 1 never answers
    v0 = n_valid;
    accept();
    do_layer(0, 5);
    wait_start();
    chk("t3_layer", o_layer, 1);
    repeat (20) tick();
    chk("t3_wait20_busy", o_busy, 1);
    chk("t3_wait20_noerr", o_error, 0);
    tick();
    chk("t3_err_busy", o_busy, 1);
    tick();
    chk("t3_idle", o_busy, 0);
    chk("t3_error", o_error, 1);
    chk("t3_novalid", n_valid - v0, 0);
    tick();
    chk("t3_error_sticky", o_error, 1);
    accept();
    chk("t3_error_clr", o_error, 0);
    do_layer(0, 5);
    do_layer(1, 5);
    do_layer(2, 5);
    finish_run(22);
    // done on the expiry cycle (WAIT cycle 20) wins: 7 + 22 + 7 + 1 = 37
    accept();
    do_layer(0, 5);
    do_layer(1, 20);
    do_layer(2, 5);
    chk("t4_noerr", o_error, 0);
    finish_run(37);
    // async reset in WAIT of layer 1
    accept();
    do_layer(0, 5);
    wait_start();
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("t5_busy", o_busy, 0);
    chk("t5_layer", o_layer, 0);
    chk("t5_n_in", o_eng_n_in, 0);
    chk("t5_wbase", o_eng_wbase, 0);
    chk("t5_bbase", o_eng_bbase, 0);
    chk("t5_relu", o_eng_relu, 0);
    chk("t5_src", o_eng_src, 0);
    chk("t5_cycles", o_run_cycles, 0);
    tick();
    rst = 1'b0;
    s0 = n_start;
    i_eng_done = 1'b1;
    tick();
    i_eng_done = 1'b0;
    tick();
    chk("t5_idle", o_busy, 0);
    chk("t5_layer_after", o_layer, 0);
    chk("t5_nostart", n_start - s0, 0);
    // done in IDLE and in LOAD is ignored
    i_eng_done = 1'b1;
    tick();
    i_eng_done = 1'b0;
    chk("t6_idle", o_busy, 0);
    accept();
    i_eng_done = 1'b1;
    tick();
    i_eng_done = 1'b0;
    chk("t6_start", o_eng_start, 1);
    do_layer(0, 5);
    do_layer(1, 5);
    do_layer(2, 5);
    finish_run(22);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1);
  end
endmodule
